// File: rtl/mips_defs.sv
// Shared MIPS decode constants and fetch FSM encoding used by the fetch/next-PC stage.
package mips_defs;

  localparam logic [5:0] OP_REGIMM = 6'b000001;
  localparam logic [5:0] OP_J      = 6'b000010;
  localparam logic [5:0] OP_JAL    = 6'b000011;
  localparam logic [5:0] OP_BEQ    = 6'b000100;
  localparam logic [5:0] OP_BNE    = 6'b000101;
  localparam logic [5:0] OP_BLEZ   = 6'b000110;
  localparam logic [5:0] OP_BGTZ   = 6'b000111;

  localparam logic [4:0] RT_BLTZ = 5'b00000;
  localparam logic [4:0] RT_BGEZ = 5'b00001;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;

  typedef enum logic {
    FETCH = 1'b0,
    EXEC  = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/npc_calc.sv
// Combinational next-PC selection: register jump, absolute jump, conditional branch or pc+4.
module npc_calc #(
  parameter int unsigned ADDR_W = 32
) (
  input  logic [ADDR_W-1:0] pc,
  input  logic [31:0]       instr,
  input  logic              branch,
  input  logic              jump,
  input  logic              jr,
  input  logic [31:0]       rs_val,
  input  logic [31:0]       rt_val,
  output logic [ADDR_W-1:0] pc_plus4,
  output logic [ADDR_W-1:0] next_pc
);
  import mips_defs::*;

  logic [5:0]        op;
  logic [4:0]        rt;
  logic [15:0]       imm16;
  logic [31:0]       pc4_w;
  logic [ADDR_W-1:0] br_target;
  logic [ADDR_W-1:0] j_target;
  logic [ADDR_W-1:0] jr_target;
  logic              taken;
  logic              unused_rs_lo;

  assign op    = instr[31:26];
  assign rt    = instr[20:16];
  assign imm16 = instr[15:0];

  assign pc_plus4  = pc + ADDR_W'(4);
  assign pc4_w     = 32'(pc_plus4);
  assign br_target = pc_plus4 + ADDR_W'({{14{imm16[15]}}, imm16, 2'b00});
  assign j_target  = ADDR_W'({pc4_w[31:28], instr[25:0], 2'b00});
  assign jr_target = ADDR_W'({rs_val[31:2], 2'b00});

  // Register targets are forced word-aligned, so the low bits never matter.
  assign unused_rs_lo = ^rs_val[1:0];

  always_comb begin
    taken = 1'b0;
    if (branch) begin
      case (op)
        OP_BEQ:    taken = (rs_val == rt_val);
        OP_BNE:    taken = (rs_val != rt_val);
        OP_BGTZ:   taken = ($signed(rs_val) > 32'sd0);
        OP_BLEZ:   taken = ($signed(rs_val) <= 32'sd0);
        OP_REGIMM: begin
          if (rt == RT_BGEZ) begin
            taken = ~rs_val[31];
          end else if (rt == RT_BLTZ) begin
            taken = rs_val[31];
          end
        end
        default:   taken = 1'b0;
      endcase
    end
  end

  always_comb begin
    next_pc = pc_plus4;
    if (jr) begin
      next_pc = jr_target;
    end else if (jump) begin
      next_pc = j_target;
    end else if (taken) begin
      next_pc = br_target;
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Single-issue fetch stage: PC register, imem req/ack fetch, instruction register and
// a two-state FETCH/EXEC sequencer that presents each instruction for one execute slot.
module instr_fetch_unit #(
  parameter int unsigned        ADDR_W   = 32,
  parameter logic [ADDR_W-1:0]  RESET_PC = ADDR_W'(mips_defs::RESET_PC_DEFAULT)
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [31:0]       imem_rdata,
  input  logic              stall,
  input  logic              branch,
  input  logic              jump,
  input  logic              jr,
  input  logic [31:0]       rs_val,
  input  logic [31:0]       rt_val,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_plus4,
  output logic [5:0]        op,
  output logic [5:0]        func,
  output logic [4:0]        rs,
  output logic [4:0]        rt,
  output logic [4:0]        rd,
  output logic [4:0]        shamt,
  output logic [15:0]       imm16,
  output logic              instr_valid,
  output logic              retire
);
  import mips_defs::*;

  fetch_state_e      state_q, state_d;
  logic              started_q;
  logic [ADDR_W-1:0] pc_q;
  logic [31:0]       instr_q;
  logic [ADDR_W-1:0] next_pc;
  logic              latch;

  // started_q keeps imem_req low until the first edge after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= FETCH;
      started_q <= 1'b0;
      pc_q      <= RESET_PC;
      instr_q   <= '0;
    end else begin
      state_q   <= state_d;
      started_q <= 1'b1;
      if (latch) begin
        instr_q <= imem_rdata;
      end
      if (retire) begin
        pc_q <= next_pc;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    imem_req    = 1'b0;
    instr_valid = 1'b0;
    retire      = 1'b0;
    latch       = 1'b0;
    case (state_q)
      FETCH: begin
        imem_req = started_q;
        if (started_q && imem_ack) begin
          latch   = 1'b1;
          state_d = EXEC;
        end
      end
      EXEC: begin
        instr_valid = 1'b1;
        if (!stall) begin
          retire  = 1'b1;
          state_d = FETCH;
        end
      end
      default: state_d = FETCH;
    endcase
  end

  npc_calc #(
    .ADDR_W (ADDR_W)
  ) u_npc_calc (
    .pc       (pc_q),
    .instr    (instr_q),
    .branch   (branch),
    .jump     (jump),
    .jr       (jr),
    .rs_val   (rs_val),
    .rt_val   (rt_val),
    .pc_plus4 (pc_plus4),
    .next_pc  (next_pc)
  );

  assign imem_addr = pc_q;
  assign pc        = pc_q;
  assign op        = instr_q[31:26];
  assign rs        = instr_q[25:21];
  assign rt        = instr_q[20:16];
  assign rd        = instr_q[15:11];
  assign shamt     = instr_q[10:6];
  assign func      = instr_q[5:0];
  assign imm16     = instr_q[15:0];

endmodule
